// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit bus to 16-bit async SRAM bridge.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_GAP,
        ST_HI,
        ST_RESP
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    function automatic bit wait_cycles_ok(input int unsigned w);
        return (w >= 1) && (w <= 15);
    endfunction

endpackage

// File: rtl/sram_phy.sv
// SRAM pad stage: registered strobes/address, tristate data driver, read capture.
module sram_phy
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_AW = 18,
    parameter int unsigned SRAM_DW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SRAM_AW-1:0]     addr_d,
    input  logic                   ce_n_d,
    input  logic                   we_n_d,
    input  logic                   oe_n_d,
    input  logic                   ub_n_d,
    input  logic                   lb_n_d,
    input  logic                   drive_d,
    input  logic [SRAM_DW-1:0]     dout_d,
    input  logic                   cap_lo,
    input  logic                   cap_hi,
    output logic [2*SRAM_DW-1:0]   rdata,
    output logic [SRAM_AW-1:0]     sram_addr,
    inout  logic [SRAM_DW-1:0]     sram_dq,
    output logic                   sram_ce_n,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    logic               drive_q;
    logic [SRAM_DW-1:0] dout_q;
    logic [SRAM_DW-1:0] rd_lo;
    logic [SRAM_DW-1:0] rd_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            drive_q   <= 1'b0;
            dout_q    <= '0;
        end else begin
            sram_addr <= addr_d;
            sram_ce_n <= ce_n_d;
            sram_we_n <= we_n_d;
            sram_oe_n <= oe_n_d;
            sram_ub_n <= ub_n_d;
            sram_lb_n <= lb_n_d;
            drive_q   <= drive_d;
            dout_q    <= dout_d;
        end
    end

    assign sram_dq = drive_q ? dout_q : 'z;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_lo <= '0;
            rd_hi <= '0;
        end else begin
            if (cap_lo) rd_lo <= sram_dq;
            if (cap_hi) rd_hi <= sram_dq;
        end
    end

    assign rdata = {rd_hi, rd_lo};

endmodule

// File: rtl/sram_word_ctrl.sv
// Word-access controller: splits each 32-bit request into two 16-bit SRAM cycles
// with byte masking and configurable wait states.
module sram_word_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned SRAM_DW     = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [SRAM_AW-2:0]     req_addr,
    input  logic [3:0]             req_be,
    input  logic [2*SRAM_DW-1:0]   req_wdata,
    output logic                   rsp_valid,
    output logic [2*SRAM_DW-1:0]   rsp_rdata,
    output logic [SRAM_AW-1:0]     sram_addr,
    inout  logic [SRAM_DW-1:0]     sram_dq,
    output logic                   sram_ce_n,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    if (!wait_cycles_ok(WAIT_CYCLES)) begin : g_bad_wait_cycles
        $error("sram_word_ctrl: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t               state, state_nx;
    logic [3:0]           cnt;
    logic                 ready_q;
    logic                 accept;
    logic                 cnt_done;

    logic                 we_q;
    logic [SRAM_AW-2:0]   addr_q;
    logic [3:0]           be_q;
    logic [2*SRAM_DW-1:0] wdata_q;

    logic                 f_we;
    logic [SRAM_AW-2:0]   f_addr;
    logic [3:0]           f_be;
    logic [2*SRAM_DW-1:0] f_wdata;

    logic [SRAM_AW-1:0]   addr_d;
    logic                 ce_n_d, we_n_d, oe_n_d, ub_n_d, lb_n_d, drive_d;
    logic [SRAM_DW-1:0]   dout_d;
    logic                 cap_lo, cap_hi;

    assign accept   = req_valid && ready_q;
    assign cnt_done = (cnt == WAIT_LAST);

    // Pins are registered from the next state, so the request fields must come
    // straight from the bus on the accept edge and from the holding regs afterwards.
    assign f_we    = accept ? req_we    : we_q;
    assign f_addr  = accept ? req_addr  : addr_q;
    assign f_be    = accept ? req_be    : be_q;
    assign f_wdata = accept ? req_wdata : wdata_q;

    always_comb begin
        state_nx = state;
        cap_lo   = 1'b0;
        cap_hi   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!req_we)                 state_nx = ST_LO;
                    else if (req_be == '0)       state_nx = ST_RESP;
                    else if (req_be[1:0] == '0)  state_nx = ST_HI;
                    else                         state_nx = ST_LO;
                end
            end
            ST_LO: begin
                if (cnt_done) begin
                    cap_lo   = !we_q;
                    state_nx = (we_q && be_q[3:2] == '0) ? ST_RESP : ST_GAP;
                end
            end
            ST_GAP:  state_nx = ST_HI;
            ST_HI: begin
                if (cnt_done) begin
                    cap_hi   = !we_q;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = sram_addr;
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        drive_d = 1'b0;
        dout_d  = '0;
        unique case (state_nx)
            ST_LO: begin
                addr_d = {f_addr, HALF_LO};
                ce_n_d = 1'b0;
                if (f_we) begin
                    we_n_d  = 1'b0;
                    lb_n_d  = ~f_be[0];
                    ub_n_d  = ~f_be[1];
                    drive_d = 1'b1;
                    dout_d  = f_wdata[SRAM_DW-1:0];
                end else begin
                    oe_n_d = 1'b0;
                    ub_n_d = 1'b0;
                    lb_n_d = 1'b0;
                end
            end
            ST_HI: begin
                addr_d = {f_addr, HALF_HI};
                ce_n_d = 1'b0;
                if (f_we) begin
                    we_n_d  = 1'b0;
                    lb_n_d  = ~f_be[2];
                    ub_n_d  = ~f_be[3];
                    drive_d = 1'b1;
                    dout_d  = f_wdata[2*SRAM_DW-1:SRAM_DW];
                end else begin
                    oe_n_d = 1'b0;
                    ub_n_d = 1'b0;
                    lb_n_d = 1'b0;
                end
            end
            ST_GAP:  addr_d = {f_addr, HALF_LO};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx == ST_IDLE);
            if ((state_nx == state) && (state == ST_LO || state == ST_HI))
                cnt <= cnt + 4'd1;
            else
                cnt <= '0;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state == ST_RESP);

    sram_phy #(
        .SRAM_AW (SRAM_AW),
        .SRAM_DW (SRAM_DW)
    ) u_phy (
        .clk       (clk),
        .rst       (rst),
        .addr_d    (addr_d),
        .ce_n_d    (ce_n_d),
        .we_n_d    (we_n_d),
        .oe_n_d    (oe_n_d),
        .ub_n_d    (ub_n_d),
        .lb_n_d    (lb_n_d),
        .drive_d   (drive_d),
        .dout_d    (dout_d),
        .cap_lo    (cap_lo),
        .cap_hi    (cap_hi),
        .rdata     (rsp_rdata),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Scoreboard bench for sram_word_ctrl: word-level reference memory, pin-level SRAM models.
module tb_sram_word_ctrl;

    localparam int unsigned W1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // WAIT_CYCLES=1 instance
    logic        req_valid, req_ready, req_we, rsp_valid;
    logic [16:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata, rsp_rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, we_n, oe_n, ub_n, lb_n;

    // WAIT_CYCLES=3 instance
    logic        req_valid3, req_ready3, req_we3, rsp_valid3;
    logic [16:0] req_addr3;
    logic [3:0]  req_be3;
    logic [31:0] req_wdata3, rsp_rdata3;
    logic [17:0] sram_addr3;
    wire  [15:0] sram_dq3;
    logic        ce_n3, we_n3, oe_n3, ub_n3, lb_n3;

    sram_word_ctrl #(.SRAM_AW(18), .SRAM_DW(16), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_addr(sram_addr),
        .sram_dq(sram_dq), .sram_ce_n(ce_n), .sram_we_n(we_n), .sram_oe_n(oe_n),
        .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    sram_word_ctrl #(.SRAM_AW(18), .SRAM_DW(16), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(req_we3), .req_addr(req_addr3), .req_be(req_be3), .req_wdata(req_wdata3),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .sram_addr(sram_addr3),
        .sram_dq(sram_dq3), .sram_ce_n(ce_n3), .sram_we_n(we_n3), .sram_oe_n(oe_n3),
        .sram_ub_n(ub_n3), .sram_lb_n(lb_n3)
    );

    // Pin-level async SRAM models
    logic [15:0] mem1 [0:1023];
    logic [15:0] mem3 [0:255];
    assign sram_dq  = (!ce_n  && !oe_n  && we_n)  ? mem1[sram_addr[9:0]] : 'z;
    assign sram_dq3 = (!ce_n3 && !oe_n3 && we_n3) ? mem3[sram_addr3[7:0]] : 'z;

    always @(negedge clk) begin
        if (rst && !ce_n && !we_n) begin
            if (!lb_n) mem1[sram_addr[9:0]][7:0]  = sram_dq[7:0];
            if (!ub_n) mem1[sram_addr[9:0]][15:8] = sram_dq[15:8];
        end
        if (rst && !ce_n3 && !we_n3) begin
            if (!lb_n3) mem3[sram_addr3[7:0]][7:0]  = sram_dq3[7:0];
            if (!ub_n3) mem3[sram_addr3[7:0]][15:8] = sram_dq3[15:8];
        end
    end

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word-level reference memory and expected-response queue
    logic [31:0] ref_mem [0:63];
    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int unsigned due;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] last_rd     = '0;
    logic [31:0] last_dut_rd = '0;
    int          ce_low_cnt  = 0;
    logic        last_lb, last_ub;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned lat(input logic we, input logic [3:0] be);
        if (!we) return 2 * W1 + 2;
        if (be == 4'h0) return 1;
        if (be[1:0] == 2'b00 || be[3:2] == 2'b00) return W1 + 1;
        return 2 * W1 + 2;
    endfunction

    // Monitor: pops an expectation every time the DUT presents a response
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d expected none", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_latency", cyc, mon_e.due);
                if (mon_e.is_rd) begin
                    last_rd     = mon_e.data;
                    last_dut_rd = rsp_rdata;
                end
                chk(mon_e.is_rd ? "rsp_rdata" : "rsp_rdata_hold", rsp_rdata, last_rd);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            tests++;
            if ((!we_n && !oe_n) || (!we_n3 && !oe_n3)) begin
                fails++;
                $display("FAIL we_oe_overlap: got we_n=0 oe_n=0 at cycle %0d expected never both low", cyc);
            end
            if (!ce_n) begin
                ce_low_cnt++;
                last_lb = lb_n;
                last_ub = ub_n;
            end
        end
    end

    task automatic issue(input logic we, input logic [5:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input bit hold);
        int unsigned n = 0;
        logic        rdy;
        exp_t        e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = {11'b0, addr};
        req_be    = be;
        req_wdata = wd;
        do begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        #1;
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got req_ready=0 for %0d cycles expected 1", n);
        end else begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
                e.data = '0;
            end else begin
                e.data = ref_mem[addr];
            end
            e.is_rd = !we;
            e.due   = cyc + lat(we, be) - 1;
            sbq.push_back(e);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Issues one access on the WAIT_CYCLES=3 instance and traces 8 cycles after accept
    task automatic run3(input logic we, input logic [31:0] wd,
                        output logic [7:0] ce_tr, output logic [7:0] rv_tr, output logic [31:0] rd);
        req_valid3 = 1'b1;
        req_we3    = we;
        req_addr3  = 17'd7;
        req_be3    = 4'hF;
        req_wdata3 = wd;
        @(negedge clk);
        chk("w3_ready", {31'b0, req_ready3}, 32'd1);
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        rd = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ce_tr[i] = ce_n3;
            rv_tr[i] = rsp_valid3;
            if (rsp_valid3) rd = rsp_rdata3;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    logic [7:0]  ce_tr, rv_tr;
    logic [31:0] rd3, v;

    initial begin
        req_valid  = 1'b1; req_we  = 1'b0; req_addr  = '0; req_be  = '0; req_wdata  = '0;
        req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = '0; req_be3 = '0; req_wdata3 = '0;
        for (int i = 0; i < 1024; i++) mem1[i] = '0;
        for (int i = 0; i < 256; i++)  mem3[i] = '0;
        for (int w = 0; w < 64; w++) begin
            v = $urandom;
            ref_mem[w]     = v;
            mem1[2*w]      = v[15:0];
            mem1[2*w + 1]  = v[31:16];
        end

        // Reset held with requests pending
        repeat (3) @(negedge clk);
        chk("rst_strobes", {27'b0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'h1F);
        chk("rst_strobes3", {27'b0, ce_n3, we_n3, oe_n3, ub_n3, lb_n3}, 32'h1F);
        chk("rst_ready", {30'b0, req_ready, req_ready3}, 32'd0);
        chk("rst_rsp_valid", {30'b0, rsp_valid, rsp_valid3}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_addr", {14'b0, sram_addr}, 32'd0);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_valid3 = 1'b0;
        chk("ready_after_release", {30'b0, req_ready, req_ready3}, 32'd3);

        // Full write then read
        issue(1'b1, 6'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        drain();
        chk("mem_lo_half", {16'b0, mem1[10'h20]}, 32'h0000BEEF);
        chk("mem_hi_half", {16'b0, mem1[10'h21]}, 32'h0000DEAD);
        issue(1'b0, 6'h10, 4'hF, 32'h0, 1'b0);
        drain();
        chk("read_full", last_dut_rd, 32'hDEADBEEF);

        // Byte-masked write touches only the low half
        ce_low_cnt = 0;
        issue(1'b1, 6'h10, 4'h2, 32'h11223344, 1'b0);
        drain();
        chk("be2_ce_cycles", ce_low_cnt, 32'd1);
        chk("be2_lb_ub", {30'b0, last_lb, last_ub}, 32'd2);
        issue(1'b0, 6'h10, 4'hF, 32'h0, 1'b0);
        drain();
        chk("read_masked", last_dut_rd, 32'hDEAD33EF);

        // be=0 write: no strobe at all
        ce_low_cnt = 0;
        issue(1'b1, 6'h05, 4'h0, $urandom, 1'b0);
        drain();
        chk("be0_ce_cycles", ce_low_cnt, 32'd0);

        // Back-to-back reads with req_valid held high
        for (int i = 1; i <= 4; i++) issue(1'b0, 6'(i), 4'hF, 32'h0, i != 4);
        drain();

        // WAIT_CYCLES=3: LO x3, GAP, HI x3, RESP
        run3(1'b1, 32'hCAFEF00D, ce_tr, rv_tr, rd3);
        chk("w3_wr_ce_trace", {24'b0, ce_tr}, 32'h88);
        chk("w3_wr_rsp_trace", {24'b0, rv_tr}, 32'h80);
        chk("w3_mem", {mem3[15], mem3[14]}, 32'hCAFEF00D);
        run3(1'b0, 32'h0, ce_tr, rv_tr, rd3);
        chk("w3_rd_ce_trace", {24'b0, ce_tr}, 32'h88);
        chk("w3_rd_rsp_trace", {24'b0, rv_tr}, 32'h80);
        chk("w3_rd_data", rd3, 32'hCAFEF00D);

        // Reset during the high half of a write
        issue(1'b1, 6'h09, 4'hF, $urandom, 1'b0);
        begin
            int unsigned n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(!ce_n && sram_addr[0]) && n < 20);
            if (n >= 20) begin
                tests++;
                fails++;
                $display("FAIL hi_phase_timeout: got no HI phase expected one");
            end
        end
        rst = 1'b0;
        #1;
        chk("abort_strobes", {27'b0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'h1F);
        chk("abort_rsp_ready", {30'b0, rsp_valid, req_ready}, 32'd0);
        sbq.delete();
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready_back", {31'b0, req_ready}, 32'd1);
        issue(1'b1, 6'h09, 4'hF, 32'h0BADF00D, 1'b0);
        issue(1'b0, 6'h09, 4'hF, 32'h0, 1'b0);
        drain();
        chk("abort_clean_read", last_dut_rd, 32'h0BADF00D);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            logic hold;
            hold = 1'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 4'($urandom),
                  $urandom, hold);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_word_ctrl.md
Name: sram_word_ctrl

Overview:
- Bridges the 32-bit MIPS memory bus to an external 16-bit asynchronous SRAM with the same pin set as the current board part: addr, dq, we, oe, ub, lb, ce.
- Splits each word access into two half-word SRAM cycles and applies byte enables on writes.
- Wait states are configurable.
- Replaces the direct core-to-RAM pin wiring. Sits between the Mips core bus and the SRAM pads.

Parameters:
- SRAM_AW, 18: SRAM half-word address width.
- SRAM_DW, 16: SRAM data width. BUS_DW is fixed at 2*SRAM_DW.
- WAIT_CYCLES, 1: cycles each SRAM access holds its strobes. Legal range 1..15.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- req_valid, input, 1: request present.
- req_ready, output, 1: controller idle and accepting.
- req_we, input, 1: 1 = write, 0 = read.
- req_addr, input, SRAM_AW-1: word address.
- req_be, input, 4: byte enables for writes. Bit0 = byte 0 (LSB).
- req_wdata, input, 2*SRAM_DW: write data.
- rsp_valid, output, 1: one-cycle completion pulse (read data or write ack).
- rsp_rdata, output, 2*SRAM_DW: read data, valid while rsp_valid=1.
- sram_addr, output, SRAM_AW: SRAM half-word address.
- sram_dq, inout, SRAM_DW: SRAM data bus.
- sram_ce_n, output, 1: chip enable, active low.
- sram_we_n, output, 1: write enable, active low.
- sram_oe_n, output, 1: output enable, active low.
- sram_ub_n, output, 1: upper byte mask, active low.
- sram_lb_n, output, 1: lower byte mask, active low.

Behaviour:
- Reset (rst low, async):
  - state=IDLE.
  - ce_n=we_n=oe_n=ub_n=lb_n=1, sram_addr=0, sram_dq=Z.
  - rsp_valid=0, rsp_rdata=0, req_ready=0.
  - req_ready rises on the first clk edge after rst releases.
- Mapping: word w occupies half-words 2w (low, bits 15:0) and 2w+1 (high, bits 31:16). Little-endian.
- States:
  - IDLE -> LO -> GAP -> HI -> RESP -> IDLE.
  - A wait counter runs 0..WAIT_CYCLES-1 in LO and HI.
- Accept: when req_valid && req_ready at a clk edge, all req fields are registered and req_ready drops.
  - Requests are ignored when req_ready=0.
  - req_ready=1 only in IDLE.
- LO / HI, for WAIT_CYCLES cycles each:
  - sram_addr={addr,0} in LO, {addr,1} in HI; ce_n=0.
  - Read: oe_n=0, ub_n=lb_n=0, dq=Z. The half-word is captured on the edge that ends the state.
  - Write: oe_n=1, we_n=0, dq driven with the matching half of wdata. lb_n=~be[0]/~be[2] and ub_n=~be[1]/~be[3] for LO/HI.
- GAP, 1 cycle:
  - ce_n=we_n=oe_n=1, dq=Z.
  - Address holds the LO value.
  - Provides write recovery and bus turnaround.
- Write skip rules:
  - be[1:0]=0: skip LO (IDLE->HI directly, no GAP).
  - be[3:2]=0: skip HI (LO->RESP directly).
  - be=0: IDLE->RESP, no SRAM strobe asserted.
  - Reads never skip.
- RESP, 1 cycle: rsp_valid=1. rsp_rdata holds {hi,lo} for reads and is unchanged on writes. No backpressure.
- Latency from the accept edge to rsp_valid high:
  - full access: 2*WAIT_CYCLES+2 cycles (4 at default);
  - single-half write: WAIT_CYCLES+1;
  - be=0 write: 1.
- Back-to-back: the next request can be accepted on the edge that leaves RESP (req_ready=1 in the following IDLE cycle). Minimum issue interval is therefore latency+1.
- Strobes:
  - All SRAM strobes are registered outputs, so they are glitch-free.
  - we_n and oe_n are never low simultaneously.
  - dq is driven only while we_n=0 in a write state.
- Reset mid-operation: strobes deassert and dq goes Z immediately. No rsp_valid is issued for the aborted access, and the SRAM write may be partial.

Decomposition:
- Package sram_ctrl_pkg:
  - state encoding (IDLE, LO, GAP, HI, RESP);
  - half-select constants;
  - a WAIT_CYCLES range check function.
- Sub-module sram_phy:
  - registered pin outputs;
  - tristate dq driver;
  - read-data input register.
- The FSM stays in sram_word_ctrl.

Test Plan:
- Reset: hold rst low 3 cycles with req_valid=1 -> all *_n=1, dq=Z, req_ready=0, rsp_valid=0. req_ready=1 one edge after release.
- Full write then read: write addr=0x00010, wdata=0xDEADBEEF, be=0xF -> SRAM model holds [0x20]=0xBEEF and [0x21]=0xDEAD, rsp_valid 4 cycles after accept. Reading the same address -> rsp_rdata=0xDEADBEEF after 4 cycles.
- Byte-masked writes:
  - be=0x2, wdata=0x11223344 onto 0xDEADBEEF -> word becomes 0xDEAD33EF. Only LO is issued (lb_n=1, ub_n=0) and the ack comes 2 cycles after accept.
  - be=0 -> no ce_n pulse, ack after 1 cycle.
- WAIT_CYCLES=3: full read -> ce_n low 3 cycles per half, 1-cycle GAP between halves, rsp_valid 8 cycles after accept.
- Back-to-back and hazard: 4 consecutive reads with req_valid held high -> each accepted exactly once, data in order, we_n/oe_n never both 0.
- Mid-operation reset: assert rst during HI of a write -> strobes high immediately, no rsp_valid, a clean new access after release.
